// File: rtl/oclib_uart_pkg.sv
// Shared UART-block definitions.
// Holds the default terminator byte and idle timeout used by the TX
// arbiter, so every top level builds on the same values, plus the
// arbiter FSM state type.
package oclib_uart_pkg;

    // Default byte that closes a message (line feed).
    localparam logic [7:0] TxArbDefaultTermByte = 8'h0A;

    // Default number of idle cycles in BUSY before the grant is released.
    localparam int TxArbDefaultTimeout = 4096;

    // Arbiter states: IDLE picks an owner, BUSY passes the owner's bytes through.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } tx_arb_state_e;

endpackage

// File: rtl/oclib_uart_tx_arbiter_if.sv
// Byte-stream bundle between N requesters, the TX arbiter and the UART TX
// byte channel.
//   inData/inValid/inReady : requester side, requester i on inData[8i+7:8i]
//   outData/outValid/outReady : UART TX side
//   grant/timeoutPulse : arbiter status
// The slave modport is the arbiter's view; master is the environment's view.
interface oclib_uart_tx_arbiter_if #(
    parameter int Requesters = 4
);
    logic [Requesters*8-1:0] inData;
    logic [Requesters-1:0]   inValid;
    logic [Requesters-1:0]   inReady;
    logic [7:0]              outData;
    logic                    outValid;
    logic                    outReady;
    logic [Requesters-1:0]   grant;
    logic                    timeoutPulse;

    modport slave (
        input  inData,
        input  inValid,
        input  outReady,
        output inReady,
        output outData,
        output outValid,
        output grant,
        output timeoutPulse
    );

    modport master (
        output inData,
        output inValid,
        output outReady,
        input  inReady,
        input  outData,
        input  outValid,
        input  grant,
        input  timeoutPulse
    );
endinterface

// File: rtl/oclib_rr_pick.sv
// Combinational round-robin picker.
// Searches req upward starting at last+1 (wrapping mod Width) and returns
// the first set bit as a one-hot vector and as an index.
//   req    : request vector
//   last   : index of the previous winner
//   onehot : one-hot winner, zero when no request
//   index  : winner index, zero when no request
//   any    : at least one request present
module oclib_rr_pick #(
    parameter int Width = 4,
    localparam int IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0]    req,
    input  logic [IdxWidth-1:0] last,
    output logic [Width-1:0]    onehot,
    output logic [IdxWidth-1:0] index,
    output logic                any
);

    logic [IdxWidth-1:0] cand_s;
    logic                hit_s;
    logic                found_s;

    // Walk the candidates in priority order; the first hit wins, later hits are masked.
    always_comb begin
        onehot  = '0;
        index   = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        found_s = 1'b0;
        for (int i = 1; i <= Width; i++) begin
            cand_s         = IdxWidth'((int'(last) + i) % Width);
            hit_s          = req[cand_s] & ~found_s;
            onehot[cand_s] = onehot[cand_s] | hit_s;
            index          = hit_s ? cand_s : index;
            found_s        = found_s | hit_s;
        end
    end

    assign any = |req;

endmodule

// File: rtl/oclib_uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART TX byte stream.
// A granted requester keeps the channel until it transfers TermByte or
// stays idle (no transfer, including stalls) for IdleTimeoutCycles cycles,
// so lines from different requesters are never interleaved on the wire.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : requester byte streams, UART TX channel, grant and
//                  timeoutPulse status (see oclib_uart_tx_arbiter_if)
module oclib_uart_tx_arbiter
    import oclib_uart_pkg::*;
#(
    parameter int         Requesters        = 4,
    parameter logic [7:0] TermByte          = TxArbDefaultTermByte,
    parameter int         IdleTimeoutCycles = TxArbDefaultTimeout,
    parameter int         TimerWidth        = $clog2(IdleTimeoutCycles + 1)
) (
    input logic clock,
    input logic reset,
    oclib_uart_tx_arbiter_if.slave bus
);

    localparam int IdxWidth  = $clog2(Requesters);
    // A disabled timeout gives a zero-width timer; keep one bit so the code stays uniform.
    localparam int TimerBits = (TimerWidth < 1) ? 1 : TimerWidth;
    localparam logic [IdxWidth-1:0]  LastInit   = IdxWidth'(Requesters - 1);
    localparam logic [TimerBits-1:0] ExpireAt   =
        TimerBits'((IdleTimeoutCycles > 0) ? (IdleTimeoutCycles - 1) : 0);
    localparam logic [TimerBits-1:0] TimerMax   = {TimerBits{1'b1}};
    localparam logic                 TimeoutOn  = (IdleTimeoutCycles > 0);

    tx_arb_state_e          state_r;
    logic [Requesters-1:0]  grant_r;
    logic [IdxWidth-1:0]    owner_r;
    logic [IdxWidth-1:0]    last_r;
    logic [TimerBits-1:0]   timer_r;
    logic                   timeout_pulse_r;

    logic [Requesters-1:0]  pick_onehot_s;
    logic [IdxWidth-1:0]    pick_index_s;
    logic                   pick_any_s;
    logic [7:0]             out_data_s;
    logic                   out_valid_s;
    logic                   xfer_s;
    logic                   is_term_s;
    logic                   expire_s;

    oclib_rr_pick #(
        .Width (Requesters)
    ) u_pick (
        .req    (bus.inValid),
        .last   (last_r),
        .onehot (pick_onehot_s),
        .index  (pick_index_s),
        .any    (pick_any_s)
    );

    // AND-OR mux on the one-hot grant: nothing reaches the UART while grant is zero.
    always_comb begin
        out_data_s  = 8'h00;
        out_valid_s = 1'b0;
        for (int i = 0; i < Requesters; i++) begin
            out_data_s  = out_data_s | (bus.inData[i*8 +: 8] & {8{grant_r[i]}});
            out_valid_s = out_valid_s | (bus.inValid[i] & grant_r[i]);
        end
    end

    assign xfer_s   = out_valid_s & bus.outReady;
    assign is_term_s = (out_data_s == TermByte);
    assign expire_s = TimeoutOn & (timer_r == ExpireAt);

    assign bus.outData      = out_data_s;
    assign bus.outValid     = out_valid_s;
    assign bus.inReady      = grant_r & {Requesters{bus.outReady}};
    assign bus.grant        = grant_r;
    assign bus.timeoutPulse = timeout_pulse_r;

    // Arbitration FSM: owner selection, release on terminator or idle timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ARB_IDLE;
            grant_r         <= '0;
            owner_r         <= '0;
            last_r          <= LastInit;
            timer_r         <= '0;
            timeout_pulse_r <= 1'b0;
        end else begin
            timeout_pulse_r <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (pick_any_s) begin
                        state_r <= ARB_BUSY;
                        grant_r <= pick_onehot_s;
                        owner_r <= pick_index_s;
                        timer_r <= '0;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_BUSY: begin
                    // A transfer always wins over a timer expiring in the same cycle.
                    if (xfer_s && is_term_s) begin
                        state_r <= ARB_IDLE;
                        grant_r <= '0;
                        last_r  <= owner_r;
                    end else if (xfer_s) begin
                        timer_r <= '0;
                    end else if (expire_s) begin
                        state_r         <= ARB_IDLE;
                        grant_r         <= '0;
                        last_r          <= owner_r;
                        timeout_pulse_r <= 1'b1;
                    end else if (timer_r != TimerMax) begin
                        timer_r <= timer_r + {{(TimerBits-1){1'b0}}, 1'b1};
                    end else begin
                        timer_r <= timer_r;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oclib_uart_tx_arbiter.sv
// Scoreboard bench for oclib_uart_tx_arbiter (4 requesters, LF terminator,
// 16-cycle idle timeout). Staged message bytes go both to the per-requester
// source queues and to a message-level round-robin model that predicts the
// wire order; a monitor pops and compares every transfer.
module tb_oclib_uart_tx_arbiter;

    localparam int         N    = 4;
    localparam int         TO   = 16;
    localparam logic [7:0] TERM = 8'h0A;

    typedef struct {
        logic [7:0] data;
        int         req;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    oclib_uart_tx_arbiter_if #(.Requesters(N)) bus ();

    oclib_uart_tx_arbiter #(
        .Requesters        (N),
        .TermByte          (TERM),
        .IdleTimeoutCycles (TO)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    logic [7:0] src_q [N][$];
    logic [7:0] stg_q [N][$];
    exp_t       exp_q [$];

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int r1_last_cyc = -1;
    int prev_xfer_cyc = -1;
    bit fair_chk = 1'b0;
    int rdy_mode = 0;
    int zero_run = 0;
    int model_last = N - 1;
    logic [N-1:0] acc = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source and UART-ready driver, updated just after each rising edge.
    initial begin
        logic [7:0] tmp;
        bus.inData   = '0;
        bus.inValid  = '0;
        bus.outReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
            end
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    bus.inValid[i]     = 1'b1;
                    bus.inData[i*8 +: 8] = src_q[i][0];
                end else begin
                    bus.inValid[i]     = 1'b0;
                    bus.inData[i*8 +: 8] = 8'($urandom);
                end
            end
            case (rdy_mode)
                0: bus.outReady = 1'b1;
                1: bus.outReady = ~bus.outReady;
                2: begin
                    if (zero_run >= 3) bus.outReady = 1'b1;
                    else bus.outReady = 1'($urandom_range(0, 1));
                    zero_run = bus.outReady ? 0 : zero_run + 1;
                end
                default: ;
            endcase
        end
    end

    // Monitor: scoreboard pop on every transfer, plus per-cycle isolation check.
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] eg;
        acc = rst ? '0 : (bus.inValid & bus.inReady);
        if (bus.timeoutPulse) pulse_cnt++;
        if (!rst && bus.grant != '0)
            check("non_owner_ready", 32'(bus.inReady & ~bus.grant), 32'h0);
        if (!rst && bus.outValid && bus.outReady) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'(bus.outData), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                eg = '0;
                eg[e.req] = 1'b1;
                check("wire_byte", 32'(bus.outData), 32'(e.data));
                check("wire_owner", 32'(bus.grant), 32'(eg));
            end
            if (bus.grant[1]) r1_last_cyc = cyc;
            if (fair_chk && prev_xfer_cyc >= 0)
                check("fair_spacing", 32'(cyc - prev_xfer_cyc), 32'd2);
            prev_xfer_cyc = cyc;
        end
    end

    function automatic bit any_pending(input bit staged);
        bit p = 1'b0;
        for (int i = 0; i < N; i++)
            p = p | (staged ? (stg_q[i].size() > 0) : (src_q[i].size() > 0));
        return p;
    endfunction

    task automatic stage(input int r, input logic [7:0] b);
        src_q[r].push_back(b);
        stg_q[r].push_back(b);
    endtask

    // Reference: whole messages, owners chosen round-robin after the previous owner.
    task automatic commit();
        int p;
        int r;
        bit done;
        logic [7:0] b;
        p = model_last;
        while (any_pending(1'b1)) begin
            r = -1;
            for (int k = 1; k <= N; k++)
                if (r < 0 && stg_q[(p + k) % N].size() > 0) r = (p + k) % N;
            done = 1'b0;
            while (!done && stg_q[r].size() > 0) begin
                b = stg_q[r].pop_front();
                exp_q.push_back('{data: b, req: r});
                done = (b == TERM);
            end
            p = r;
        end
        model_last = p;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() > 0 || any_pending(1'b0)) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'h0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic random_msg(input int r, input int len);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            if (b == TERM) b = 8'h41;
            stage(r, b);
        end
        stage(r, TERM);
    endtask

    initial begin
        int p;
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int p;
        bit seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_grant", 32'(bus.grant), 32'h0);
        check("reset_outvalid", 32'(bus.outValid), 32'h0);
        check("reset_inready", 32'(bus.inReady), 32'h0);
        check("reset_pulse", 32'(bus.timeoutPulse), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Two lines, requester 0 wins first, one-cycle arbitration latency.
        rdy_mode = 0;
        stage(0, 8'h41); stage(0, TERM);
        stage(2, 8'h42); stage(2, TERM);
        commit();
        @(posedge clk); #2;
        check("arb_latency_idle", 32'(bus.grant), 32'h0);
        @(posedge clk); #2;
        check("first_grant", 32'(bus.grant), 32'h1);
        drain("two_lines");

        // Unterminated message from requester 1 released by the idle timeout.
        rdy_mode = 2;
        stage(1, 8'h78); stage(1, 8'h79);
        stage(2, 8'h5A); stage(2, TERM);
        commit();
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk); #2;
            seen = bus.timeoutPulse;
        end
        check("timeout_seen", 32'(seen), 32'h1);
        check("timeout_distance", 32'(cyc - r1_last_cyc), 32'd17);
        check("timeout_grant_idle", 32'(bus.grant), 32'h0);
        @(posedge clk); #2;
        check("timeout_pulse_width", 32'(bus.timeoutPulse), 32'h0);
        check("timeout_next_grant", 32'(bus.grant), 32'h4);
        drain("timeout");
        check("pulse_count_1", 32'(pulse_cnt), 32'd1);

        // Toggling ready: requester 3 eight bytes, requester 0 waiting.
        rdy_mode = 1;
        random_msg(3, 7);
        stage(0, 8'h43); stage(0, TERM);
        commit();
        drain("toggle");

        // Fairness with single-byte messages from everyone.
        rdy_mode = 0;
        for (int m = 0; m < 3; m++)
            for (int r = 0; r < N; r++) stage(r, TERM);
        commit();
        prev_xfer_cyc = -1;
        fair_chk = 1'b1;
        drain("fairness");
        fair_chk = 1'b0;

        // Terminator accepted on the very cycle the timer would expire.
        rdy_mode = 3;
        bus.outReady = 1'b0;
        stage(1, TERM);
        commit();
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #2;
            seen = (bus.grant != '0);
        end
        check("term_race_grant", 32'(bus.grant), 32'h2);
        repeat (15) @(posedge clk);
        #2;
        bus.outReady = 1'b1;
        @(posedge clk); #2;
        check("term_race_release", 32'(bus.grant), 32'h0);
        check("term_race_pulse", 32'(bus.timeoutPulse), 32'h0);
        drain("term_race");
        check("pulse_count_2", 32'(pulse_cnt), 32'd1);

        // Reset while a byte is stalled in BUSY.
        bus.outReady = 1'b0;
        stage(2, 8'h51); stage(2, TERM);
        commit();
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #2;
            seen = (bus.grant != '0);
        end
        check("stall_grant", 32'(bus.grant), 32'h4);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        check("midreset_grant", 32'(bus.grant), 32'h0);
        check("midreset_inready", 32'(bus.inReady), 32'h0);
        check("midreset_outvalid", 32'(bus.outValid), 32'h0);
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            stg_q[i].delete();
        end
        exp_q.delete();
        model_last = N - 1;
        @(posedge clk); #2;
        rst = 1'b0;
        rdy_mode = 0;
        stage(3, 8'h33); stage(3, TERM);
        stage(2, 8'h32); stage(2, TERM);
        stage(0, 8'h30); stage(0, TERM);
        commit();
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("post_reset_first", 32'(bus.grant), 32'h1);
        drain("post_reset");

        // Randomized message mixes under random bounded backpressure.
        rdy_mode = 2;
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    p = $urandom_range(1, 2);
                    for (int m = 0; m < p; m++) random_msg(r, $urandom_range(0, 5));
                end
            end
            commit();
            drain("random");
        end
        check("pulse_count_final", 32'(pulse_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
